// File: rtl/m_ext_pkg.sv
// Shared M-extension definitions: operation encoding, data width and the
// product word selector used by the multiplier final stage.
package m_ext_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULH   = 2'd1,
      MULHSU = 2'd2,
      MULHU  = 2'd3
   } mul_op_t;

   // Sign handling is resolved upstream, so all high-word ops share one path.
   function automatic logic [XLEN-1:0] select_word(input logic [2*XLEN-1:0] prod,
                                                   input mul_op_t op);
      logic [XLEN-1:0] word;
      case (op)
         MUL:                 word = prod[XLEN-1:0];
         MULH, MULHSU, MULHU: word = prod[2*XLEN-1:XLEN];
         default:             word = prod[2*XLEN-1:XLEN];
      endcase
      return word;
   endfunction

endpackage

// File: rtl/mul_final_stage_cpa64.sv
// Combinational 64-bit carry-propagate adder resolving the compressor output;
// isolated so the adder architecture can be swapped independently.
module cpa64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic [63:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/mul_final_stage.sv
// Registered final stage of the Wallace-tree multiplier: captures the carry/sum
// pair, resolves it with a 64-bit add and delivers the selected product word.
module mul_final_stage
   import m_ext_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [63:0]       in_c,
   input  logic [63:0]       in_s,
   input  mul_op_t           in_op,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic [TAG_W-1:0]  out_tag,
   output logic              busy
);

   // Carry bit 63 would land at weight 2^64 and is dropped, so it is not stored.
   logic              s1_valid_r;
   logic [62:0]       s1_c_r;
   logic [63:0]       s1_s_r;
   mul_op_t           s1_op_r;
   logic [TAG_W-1:0]  s1_tag_r;

   logic              s2_valid_r;
   logic [XLEN-1:0]   s2_result_r;
   logic [TAG_W-1:0]  s2_tag_r;

   logic              s2_adv_s;
   logic [63:0]       prod_s;

   assign s2_adv_s = !s2_valid_r || out_ready;
   // Combinational path from out_ready to in_ready: there is no skid buffer.
   assign in_ready = !rst && !flush && (!s1_valid_r || s2_adv_s);

   cpa64 u_cpa64 (
      .a   (s1_s_r),
      .b   ({s1_c_r, 1'b0}),
      .sum (prod_s)
   );

   // Stage 1: capture compressor vectors on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_c_r     <= 63'd0;
         s1_s_r     <= 64'd0;
         s1_op_r    <= MUL;
         s1_tag_r   <= '0;
      end else if (flush) begin
         s1_valid_r <= 1'b0;
      end else if (in_ready) begin
         s1_valid_r <= in_valid;
         s1_c_r     <= in_c[62:0];
         s1_s_r     <= in_s;
         s1_op_r    <= in_op;
         s1_tag_r   <= in_tag;
      end
   end

   // Stage 2: register the resolved, word-selected result.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_r  <= 1'b0;
         s2_result_r <= '0;
         s2_tag_r    <= '0;
      end else if (flush) begin
         s2_valid_r  <= 1'b0;
      end else if (s2_adv_s) begin
         s2_valid_r  <= s1_valid_r;
         s2_result_r <= select_word(prod_s, s1_op_r);
         s2_tag_r    <= s1_tag_r;
      end
   end

   assign out_valid  = s2_valid_r;
   assign out_result = s2_result_r;
   assign out_tag    = s2_tag_r;
   assign busy       = s1_valid_r || s2_valid_r;

endmodule

// File: tb/tb_mul_final_stage.sv
// Directed self-checking bench for mul_final_stage: latency, word select,
// wrap-around, backpressure ordering, flush and mid-operation reset.
module tb_mul_final_stage;
   import m_ext_pkg::*;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_c;
   logic [63:0] in_s;
   mul_op_t     in_op;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] bp_c   [4];
   logic [63:0] bp_s   [4];
   mul_op_t     bp_op  [4];
   logic [4:0]  bp_tag [4];
   logic [31:0] bp_exp [4];
   int          tx;
   int          rx;
   logic        acc;
   logic        del;

   mul_final_stage #(.TAG_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_c       (in_c),
      .in_s       (in_s),
      .in_op      (in_op),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(input string name, input logic [63:0] c, input logic [63:0] s,
                          input mul_op_t op, input logic [4:0] tag, input logic [31:0] exp);
      in_c      = c;
      in_s      = s;
      in_op     = op;
      in_tag    = tag;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check({name, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      #1;
      check({name, "_valid_n1"}, 32'(out_valid), 32'd0);
      tick();
      check({name, "_valid_n2"}, 32'(out_valid), 32'd1);
      check({name, "_result"}, out_result, exp);
      check({name, "_tag"}, 32'(out_tag), 32'(tag));
      tick();
      check({name, "_drained"}, 32'(out_valid), 32'd0);
      check({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_c = 64'd0; in_s = 64'd0; in_op = MUL; in_tag = 5'd0;

      bp_c[0] = 64'h1;                   bp_s[0] = 64'h10;
      bp_op[0] = MUL;    bp_tag[0] = 5'd1; bp_exp[0] = 32'h0000_0012;
      bp_c[1] = 64'h0;                   bp_s[1] = 64'h0000_0005_0000_0000;
      bp_op[1] = MULHU;  bp_tag[1] = 5'd2; bp_exp[1] = 32'h0000_0005;
      bp_c[2] = 64'h4;                   bp_s[2] = 64'h20;
      bp_op[2] = MUL;    bp_tag[2] = 5'd3; bp_exp[2] = 32'h0000_0028;
      bp_c[3] = 64'h0000_0000_8000_0000; bp_s[3] = 64'hFFFF_FFFE_0000_0000;
      bp_op[3] = MULHSU; bp_tag[3] = 5'd4; bp_exp[3] = 32'hFFFF_FFFF;

      // Reset state
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_result", out_result, 32'd0);
      check("post_rst_tag", 32'(out_tag), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      // Word select, carry weighting and wrap-around
      run_one("basic_mul", 64'h3, 64'h6, MUL, 5'd7, 32'h0000_000C);
      run_one("high_mulh", 64'h0, 64'hFFFF_FFFF_0000_0000, MULH, 5'd8, 32'hFFFF_FFFF);
      run_one("high_mul", 64'h0, 64'hFFFF_FFFF_0000_0000, MUL, 5'd9, 32'h0000_0000);
      run_one("wrap_mulhu", 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, MULHU, 5'd10, 32'h0000_0000);
      run_one("wrap_mul", 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, MUL, 5'd11, 32'h0000_0001);
      run_one("cross_mulh", 64'h1, 64'h0000_0000_FFFF_FFFF, MULH, 5'd12, 32'h0000_0001);
      run_one("cross_mul", 64'h1, 64'h0000_0000_FFFF_FFFF, MUL, 5'd13, 32'h0000_0001);
      run_one("mulhsu", 64'h0000_0000_8000_0000, 64'h0000_0001_0000_0000, MULHSU, 5'd14, 32'h0000_0002);

      // Back-to-back with out_ready low for cycles 2..4
      tx = 0;
      rx = 0;
      for (int cyc = 0; cyc < 30 && rx < 4; cyc++) begin
         out_ready = (cyc >= 2 && cyc <= 4) ? 1'b0 : 1'b1;
         if (tx < 4) begin
            in_valid = 1'b1;
            in_c     = bp_c[tx];
            in_s     = bp_s[tx];
            in_op    = bp_op[tx];
            in_tag   = bp_tag[tx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc == 1) check("bp_in_ready_s1_only", 32'(in_ready), 32'd1);
         if (cyc == 2) check("bp_in_ready_full", 32'(in_ready), 32'd0);
         if (cyc == 3) check("bp_stall_valid", 32'(out_valid), 32'd1);
         if (out_valid && !out_ready) begin
            check("bp_stall_result", out_result, bp_exp[rx]);
            check("bp_stall_tag", 32'(out_tag), 32'(bp_tag[rx]));
         end
         acc = in_valid && in_ready;
         del = out_valid && out_ready;
         if (del) begin
            if (rx < 4) begin
               check("bp_result", out_result, bp_exp[rx]);
               check("bp_tag", 32'(out_tag), 32'(bp_tag[rx]));
            end
            rx++;
         end
         tick();
         if (acc) tx++;
      end
      in_valid = 1'b0;
      check("bp_accepted", 32'(tx), 32'd4);
      check("bp_delivered", 32'(rx), 32'd4);
      tick();
      check("bp_no_dup_valid", 32'(out_valid), 32'd0);
      check("bp_no_dup_busy", 32'(busy), 32'd0);

      // Flush with S1 and S2 occupied and a new op offered
      out_ready = 1'b0;
      in_valid = 1'b1; in_c = 64'h0; in_s = 64'h55; in_op = MUL; in_tag = 5'd20;
      tick();
      in_s = 64'h66; in_tag = 5'd21;
      tick();
      check("fl_pre_valid", 32'(out_valid), 32'd1);
      check("fl_pre_busy", 32'(busy), 32'd1);
      in_s = 64'h77; in_tag = 5'd22; flush = 1'b1;
      #1;
      check("fl_in_ready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check("fl_out_valid", 32'(out_valid), 32'd0);
      check("fl_busy", 32'(busy), 32'd0);
      tick();
      check("fl_never_out", 32'(out_valid), 32'd0);
      tick();
      check("fl_never_out2", 32'(out_valid), 32'd0);

      // Reset with both stages occupied
      out_ready = 1'b0;
      in_valid = 1'b1; in_c = 64'h1; in_s = 64'h1234; in_op = MUL; in_tag = 5'd25;
      tick();
      in_tag = 5'd26;
      tick();
      check("rm_pre_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      in_valid = 1'b0;
      check("rm_out_valid", 32'(out_valid), 32'd0);
      check("rm_out_result", out_result, 32'd0);
      check("rm_out_tag", 32'(out_tag), 32'd0);
      check("rm_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      run_one("rm_after", 64'h0000_0000_0000_0010, 64'h0000_0003_0000_0001, MULHU, 5'd27, 32'h0000_0003);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
